// File: rtl/axis_frame_sink.sv
// ---------------------------------------------------------------------------
// axis_frame_sink
// AXI-Stream slave endpoint that terminates a time-tag stream. Every frame is
// reduced to one statistics record (beat count, byte count from tkeep, tuser
// of the first beat, keep/length error flags) presented on a valid/ready side
// channel. Running frame and error counters are kept alongside.
//
// Ports
//   clk, rst           single rising-edge clock, async active-high reset
//   enable             0 holds s_axis_tready low (stream stalls, state kept)
//   s_axis_*           AXI-Stream slave (tdata is not stored)
//   stat_valid/ready   record handshake
//   stat_words         beats in frame, saturates at MAX_WORDS+1
//   stat_bytes         sum of set tkeep bits, saturating
//   stat_user          tuser of the first beat
//   stat_err_keep      illegal tkeep seen somewhere in the frame
//   stat_err_len       frame ran past MAX_WORDS beats
//   frame_count        frames completed (wraps)
//   error_count        frames with any error flag (wraps)
// ---------------------------------------------------------------------------
module axis_frame_sink #(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 32,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int MAX_WORDS  = 1024,
  parameter int CNT_WIDTH  = 32,
  localparam int WORDS_W   = $clog2(MAX_WORDS + 2),
  localparam int BYTES_W   = $clog2(MAX_WORDS * KEEP_WIDTH + 1) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic                  s_axis_tready,
  output logic                  stat_valid,
  input  logic                  stat_ready,
  output logic [WORDS_W-1:0]    stat_words,
  output logic [BYTES_W-1:0]    stat_bytes,
  output logic [USER_WIDTH-1:0] stat_user,
  output logic                  stat_err_keep,
  output logic                  stat_err_len,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic [CNT_WIDTH-1:0]  error_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FRAME = 2'd1;
  localparam logic [1:0] ST_OVF   = 2'd2;

  localparam logic [WORDS_W-1:0]   WORDS_ONE = {{(WORDS_W-1){1'b0}}, 1'b1};
  localparam logic [WORDS_W-1:0]   WORDS_SAT = WORDS_W'(MAX_WORDS + 32'd1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Number of set byte enables in one beat.
  function automatic logic [BYTES_W-1:0] keep_popcount(input logic [KEEP_WIDTH-1:0] k);
    logic [BYTES_W-1:0] n;
    n = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      n = n + {{(BYTES_W-1){1'b0}}, k[i]};
    end
    return n;
  endfunction

  // Non-last beats must be full; the last beat must be a nonzero run of ones
  // starting at byte 0 (k & (k+1) is zero only for such runs, incl. all ones).
  function automatic logic keep_illegal(input logic [KEEP_WIDTH-1:0] k, input logic last);
    logic [KEEP_WIDTH-1:0] k_inc;
    k_inc = k + {{(KEEP_WIDTH-1){1'b0}}, 1'b1};
    if (last) begin
      return (k == '0) || ((k & k_inc) != '0);
    end else begin
      return (k != '1);
    end
  endfunction

  logic [1:0]            state_r;
  logic [WORDS_W-1:0]    words_r;
  logic [BYTES_W-1:0]    bytes_r;
  logic [USER_WIDTH-1:0] user_r;
  logic                  err_keep_r;
  logic                  err_len_r;

  logic [1:0]            nxt_state_s;
  logic [WORDS_W-1:0]    nxt_words_s;
  logic [BYTES_W-1:0]    nxt_bytes_s;
  logic [USER_WIDTH-1:0] nxt_user_s;
  logic                  nxt_err_keep_s;
  logic                  nxt_err_len_s;
  logic                  emit_s;

  logic                  accept_s;
  logic [BYTES_W-1:0]    beat_bytes_s;
  logic                  beat_bad_s;
  logic [BYTES_W:0]      bytes_sum_s;
  logic [BYTES_W-1:0]    bytes_sat_s;
  logic                  unused_s;

  // tready only looks at enable and the record slot, never at tvalid.
  assign s_axis_tready = ~rst & enable & (~stat_valid | stat_ready);
  assign accept_s      = s_axis_tvalid & s_axis_tready;
  assign beat_bytes_s  = keep_popcount(s_axis_tkeep);
  assign beat_bad_s    = keep_illegal(s_axis_tkeep, s_axis_tlast);
  assign bytes_sum_s   = {1'b0, bytes_r} + {1'b0, beat_bytes_s};
  assign bytes_sat_s   = bytes_sum_s[BYTES_W] ? {BYTES_W{1'b1}} : bytes_sum_s[BYTES_W-1:0];
  assign unused_s      = ^{s_axis_tdata, 1'b0};

  // Next-state / accumulator update for one accepted beat.
  always_comb begin
    nxt_state_s    = state_r;
    nxt_words_s    = words_r;
    nxt_bytes_s    = bytes_r;
    nxt_user_s     = user_r;
    nxt_err_keep_s = err_keep_r;
    nxt_err_len_s  = err_len_r;
    emit_s         = 1'b0;
    if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          nxt_words_s    = WORDS_ONE;
          nxt_bytes_s    = beat_bytes_s;
          nxt_user_s     = s_axis_tuser;
          nxt_err_keep_s = beat_bad_s;
          nxt_err_len_s  = 1'b0;
          if (s_axis_tlast) begin
            emit_s      = 1'b1;
            nxt_state_s = ST_IDLE;
          end else begin
            nxt_state_s = ST_FRAME;
          end
        end
        ST_FRAME: begin
          nxt_words_s    = words_r + WORDS_ONE;
          nxt_bytes_s    = bytes_sat_s;
          nxt_err_keep_s = err_keep_r | beat_bad_s;
          if (nxt_words_s == WORDS_SAT) begin
            nxt_err_len_s = 1'b1;
            nxt_state_s   = ST_OVF;
          end else begin
            nxt_state_s   = ST_FRAME;
          end
          // A tlast on the overflowing beat closes the frame directly.
          if (s_axis_tlast) begin
            emit_s      = 1'b1;
            nxt_state_s = ST_IDLE;
          end else begin
            emit_s      = 1'b0;
          end
        end
        ST_OVF: begin
          // words and bytes stay frozen at their saturated values
          nxt_err_keep_s = err_keep_r | beat_bad_s;
          if (s_axis_tlast) begin
            emit_s      = 1'b1;
            nxt_state_s = ST_IDLE;
          end else begin
            nxt_state_s = ST_OVF;
          end
        end
        default: begin
          nxt_state_s = ST_IDLE;
        end
      endcase
    end else begin
      emit_s = 1'b0;
    end
  end

  // Frame accumulator and FSM registers; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      words_r    <= '0;
      bytes_r    <= '0;
      user_r     <= '0;
      err_keep_r <= 1'b0;
      err_len_r  <= 1'b0;
    end else begin
      state_r    <= nxt_state_s;
      words_r    <= nxt_words_s;
      bytes_r    <= nxt_bytes_s;
      user_r     <= nxt_user_s;
      err_keep_r <= nxt_err_keep_s;
      err_len_r  <= nxt_err_len_s;
    end
  end

  // Record slot and counters. A new record can only arrive when the slot is
  // empty or being consumed this cycle (tready guarantees it), so loading
  // over a consumed record keeps stat_valid high without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_valid    <= 1'b0;
      stat_words    <= '0;
      stat_bytes    <= '0;
      stat_user     <= '0;
      stat_err_keep <= 1'b0;
      stat_err_len  <= 1'b0;
      frame_count   <= '0;
      error_count   <= '0;
    end else if (emit_s) begin
      stat_valid    <= 1'b1;
      stat_words    <= nxt_words_s;
      stat_bytes    <= nxt_bytes_s;
      stat_user     <= nxt_user_s;
      stat_err_keep <= nxt_err_keep_s;
      stat_err_len  <= nxt_err_len_s;
      frame_count   <= frame_count + CNT_ONE;
      if (nxt_err_keep_s | nxt_err_len_s) begin
        error_count <= error_count + CNT_ONE;
      end else begin
        error_count <= error_count;
      end
    end else if (stat_ready) begin
      stat_valid    <= 1'b0;
    end else begin
      stat_valid    <= stat_valid;
    end
  end

endmodule

// File: tb/tb_axis_frame_sink.sv
module tb_axis_frame_sink;

  localparam int DW   = 64;
  localparam int UW   = 32;
  localparam int KW   = 8;
  localparam int MAXW = 4;
  localparam int CW   = 32;
  localparam int WW   = $clog2(MAXW + 2);
  localparam int BW   = $clog2(MAXW * KW + 1) + 1;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          s_axis_tvalid;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tlast;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tready;
  logic          stat_valid;
  logic          stat_ready;
  logic [WW-1:0] stat_words;
  logic [BW-1:0] stat_bytes;
  logic [UW-1:0] stat_user;
  logic          stat_err_keep;
  logic          stat_err_len;
  logic [CW-1:0] frame_count;
  logic [CW-1:0] error_count;

  axis_frame_sink #(
    .DATA_WIDTH(DW), .USER_WIDTH(UW), .KEEP_WIDTH(KW), .MAX_WORDS(MAXW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
    .stat_valid(stat_valid), .stat_ready(stat_ready), .stat_words(stat_words),
    .stat_bytes(stat_bytes), .stat_user(stat_user), .stat_err_keep(stat_err_keep),
    .stat_err_len(stat_err_len), .frame_count(frame_count), .error_count(error_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [KW-1:0] keep; logic last; logic [UW-1:0] user; } beat_t;
  typedef struct { int words; int bytes; logic [UW-1:0] user; logic ek; logic el; } rec_t;
  typedef struct {
    int n; logic [KW-1:0] kf; logic [KW-1:0] km; logic [KW-1:0] kl; logic [UW-1:0] user;
    int words; int bytes; logic ek; logic el;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  beat_t src[$];
  rec_t  exp_q[$];
  logic  exp_sv;
  int    exp_fc, exp_ec;
  int    cur_n, cur_bytes;
  logic  cur_ek;
  logic [UW-1:0] cur_user;
  int    n_rec;
  rec_t  last_rec;
  int    valid_pct, ready_pct, en_pct;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Legal keep: full for non-last beats, 2^k-1 (k=1..KW) for the last beat.
  function automatic bit keep_ok(input logic [KW-1:0] k, input bit last);
    logic [KW:0] m;
    if (!last) return k == {KW{1'b1}};
    for (int j = 1; j <= KW; j++) begin
      m = (9'd1 << j) - 9'd1;
      if (k == m[KW-1:0]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    exp_sv = 1'b0; exp_fc = 0; exp_ec = 0; cur_n = 0; cur_bytes = 0; cur_ek = 1'b0;
    cur_user = '0; exp_q.delete();
  endtask

  // Frame-level reference: record = f(all beats of the frame).
  task automatic model_beat(input logic [KW-1:0] k, input logic last, input logic [UW-1:0] u);
    rec_t r;
    if (cur_n == 0) begin cur_user = u; cur_bytes = 0; cur_ek = 1'b0; end
    cur_n++;
    if (cur_n <= MAXW + 1) cur_bytes += $countones(k);
    if (!keep_ok(k, last)) cur_ek = 1'b1;
    if (last) begin
      r.words = (cur_n > MAXW) ? MAXW + 1 : cur_n;
      r.bytes = cur_bytes;
      r.user  = cur_user;
      r.ek    = cur_ek;
      r.el    = (cur_n > MAXW);
      exp_q.push_back(r);
      exp_fc++;
      if (r.ek || r.el) exp_ec++;
      cur_n = 0;
    end
  endtask

  // One clock: check at negedge, update model, drive new inputs after posedge.
  task automatic tick();
    logic acc, cons, nsv;
    beat_t b;
    @(negedge clk);
    acc  = s_axis_tvalid & s_axis_tready;
    cons = stat_valid & stat_ready;
    chk("tready", s_axis_tready, enable & (~exp_sv | stat_ready));
    chk("stat_valid", stat_valid, exp_sv);
    chk("frame_count", frame_count, exp_fc);
    chk("error_count", error_count, exp_ec);
    if (stat_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_record", 1'b1, 1'b0);
      end else begin
        chk("rec_words", stat_words, exp_q[0].words);
        chk("rec_bytes", stat_bytes, exp_q[0].bytes);
        chk("rec_user", stat_user, exp_q[0].user);
        chk("rec_err_keep", stat_err_keep, exp_q[0].ek);
        chk("rec_err_len", stat_err_len, exp_q[0].el);
      end
    end
    nsv = exp_sv;
    if (cons) begin
      last_rec = '{int'(stat_words), int'(stat_bytes), stat_user, stat_err_keep, stat_err_len};
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      n_rec++;
      nsv = 1'b0;
    end
    if (acc) begin
      model_beat(s_axis_tkeep, s_axis_tlast, s_axis_tuser);
      if (s_axis_tlast) nsv = 1'b1;
    end
    @(posedge clk);
    exp_sv = nsv;
    #1;
    if (!(s_axis_tvalid && !acc)) begin
      if (src.size() > 0 && ($urandom % 100) < valid_pct) begin
        b = src.pop_front();
        s_axis_tvalid = 1'b1;
        s_axis_tkeep  = b.keep;
        s_axis_tlast  = b.last;
        s_axis_tuser  = b.user;
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tkeep  = KW'($urandom);
        s_axis_tlast  = 1'($urandom);
        s_axis_tuser  = $urandom;
      end
      s_axis_tdata = {$urandom, $urandom};
    end
    stat_ready = (($urandom % 100) < ready_pct);
    enable     = (($urandom % 100) < en_pct);
  endtask

  task automatic drain(input string name, input int budget);
    int c;
    c = 0;
    while ((src.size() > 0 || s_axis_tvalid || exp_q.size() > 0 || exp_sv) && c < budget) begin
      tick();
      c++;
    end
    chk({name, "_in_budget"}, (c < budget), 1'b1);
  endtask

  task automatic push_frame(input int n, input logic [KW-1:0] kf, input logic [KW-1:0] km,
                            input logic [KW-1:0] kl, input logic [UW-1:0] user);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.last = (i == n - 1);
      b.keep = b.last ? kl : ((i == 0) ? kf : km);
      b.user = (i == 0) ? user : $urandom;
      src.push_back(b);
    end
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_tready"}, s_axis_tready, 1'b0);
    chk({name, "_stat_valid"}, stat_valid, 1'b0);
    chk({name, "_words"}, stat_words, '0);
    chk({name, "_bytes"}, stat_bytes, '0);
    chk({name, "_user"}, stat_user, '0);
    chk({name, "_err_keep"}, stat_err_keep, 1'b0);
    chk({name, "_err_len"}, stat_err_len, 1'b0);
    chk({name, "_frame_count"}, frame_count, '0);
    chk({name, "_error_count"}, error_count, '0);
  endtask

  vec_t vecs[11];

  initial begin
    int ec_tab, guard, len, k, fc0;
    logic [KW:0] m;

    vecs[0]  = '{1, 8'hFF, 8'hFF, 8'hFF, 32'h5,        1,  8, 1'b0, 1'b0};
    vecs[1]  = '{4, 8'hFF, 8'hFF, 8'h07, 32'hA1,       4, 27, 1'b0, 1'b0};
    vecs[2]  = '{2, 8'hF0, 8'hFF, 8'hFF, 32'hB2,       2, 12, 1'b1, 1'b0};
    vecs[3]  = '{1, 8'hFF, 8'hFF, 8'h05, 32'hC3,       1,  2, 1'b1, 1'b0};
    vecs[4]  = '{7, 8'hFF, 8'hFF, 8'hFF, 32'hD4,       5, 40, 1'b0, 1'b1};
    vecs[5]  = '{5, 8'hFF, 8'hFF, 8'h01, 32'hE5,       5, 33, 1'b0, 1'b1};
    vecs[6]  = '{4, 8'hFF, 8'hFF, 8'h00, 32'hF6,       4, 24, 1'b1, 1'b0};
    vecs[7]  = '{3, 8'hFF, 8'h7F, 8'hFF, 32'h17,       3, 23, 1'b1, 1'b0};
    vecs[8]  = '{1, 8'hFF, 8'hFF, 8'h80, 32'h28,       1,  1, 1'b1, 1'b0};
    vecs[9]  = '{2, 8'hFF, 8'hFF, 8'h0F, 32'h39,       2, 12, 1'b0, 1'b0};
    vecs[10] = '{6, 8'hFF, 8'hFF, 8'h0F, 32'hDEADBEEF, 5, 40, 1'b0, 1'b1};

    rst = 1'b1; enable = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tlast = 1'b0; s_axis_tuser = '0; stat_ready = 1'b0;
    valid_pct = 100; ready_pct = 100; en_pct = 100; n_rec = 0;
    last_rec = '{0, 0, '0, 1'b0, 1'b0};
    model_reset();
    #3;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: one frame per vector, free-flowing handshakes.
    ec_tab = 0;
    for (int i = 0; i < 11; i++) begin
      push_frame(vecs[i].n, vecs[i].kf, vecs[i].km, vecs[i].kl, vecs[i].user);
      drain($sformatf("vec%0d", i), 100);
      if (vecs[i].ek || vecs[i].el) ec_tab++;
      chk($sformatf("vec%0d_words", i), last_rec.words, vecs[i].words);
      chk($sformatf("vec%0d_bytes", i), last_rec.bytes, vecs[i].bytes);
      chk($sformatf("vec%0d_user", i), last_rec.user, vecs[i].user);
      chk($sformatf("vec%0d_err_keep", i), last_rec.ek, vecs[i].ek);
      chk($sformatf("vec%0d_err_len", i), last_rec.el, vecs[i].el);
      chk($sformatf("vec%0d_frame_count", i), frame_count, i + 1);
      chk($sformatf("vec%0d_error_count", i), error_count, ec_tab);
    end

    // Back-pressure: record 1 held, frame 2 must stall, then a same-cycle
    // consume + tlast accept keeps stat_valid high with the new record.
    fc0 = exp_fc;
    ready_pct = 0; stat_ready = 1'b0;
    push_frame(1, 8'hFF, 8'hFF, 8'hFF, 32'h11);
    push_frame(1, 8'hFF, 8'hFF, 8'h03, 32'h22);
    repeat (6) tick();
    chk("bp_stat_valid", stat_valid, 1'b1);
    chk("bp_tready", s_axis_tready, 1'b0);
    chk("bp_frame2_pending", s_axis_tvalid & s_axis_tlast, 1'b1);
    chk("bp_frame_count", frame_count, fc0 + 1);
    chk("bp_user1", stat_user, 32'h11);
    ready_pct = 100; stat_ready = 1'b1;
    tick();
    chk("bp_no_bubble", stat_valid, 1'b1);
    chk("bp_user2", stat_user, 32'h22);
    chk("bp_bytes2", stat_bytes, 2);
    chk("bp_frame_count2", frame_count, fc0 + 2);
    drain("bp", 50);

    // Reset in the middle of a 3-beat frame.
    push_frame(3, 8'hFF, 8'hFF, 8'hFF, 32'h33);
    guard = 0;
    while (cur_n < 2 && guard < 20) begin tick(); guard++; end
    chk("midrst_reached_beat2", cur_n, 2);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    s_axis_tvalid = 1'b0; src.delete(); model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_frame(1, 8'hFF, 8'hFF, 8'hFF, 32'h77);
    drain("postrst", 50);
    chk("postrst_words", last_rec.words, 1);
    chk("postrst_user", last_rec.user, 32'h77);
    chk("postrst_frame_count", frame_count, 1);

    // Random throttled traffic, 1000 frames, scoreboard checks every record.
    for (int f = 0; f < 1000; f++) begin
      beat_t b;
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        b.last = (i == len - 1);
        if (($urandom % 100) < 85) begin
          if (b.last) begin
            k = $urandom_range(1, KW);
            m = (9'd1 << k) - 9'd1;
            b.keep = m[KW-1:0];
          end else begin
            b.keep = 8'hFF;
          end
        end else begin
          b.keep = KW'($urandom);
        end
        b.user = $urandom;
        src.push_back(b);
      end
    end
    fc0 = n_rec;
    valid_pct = 70; ready_pct = 60; en_pct = 85;
    drain("random", 60000);
    chk("random_record_count", n_rec - fc0, 1000);
    chk("random_frame_count", frame_count, 1001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
